// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Immediate generator placed between decode and execute. Each accepted
// instruction word is decoded into its sign- or zero-extended immediate at
// DATAWIDTH bits. The result is registered with a side-band tag, behind a
// two-entry skid buffer. The block sustains one entry per cycle with one
// cycle of latency. Ready_o is a flop output, so no combinational path runs
// from Ready_i to Ready_o.
//
// Parameters
//   DATAWIDTH    immediate width, 32 or 64
//   TAGWIDTH     width of the tag that travels with each immediate
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_n_i      asynchronous active-low reset
//   Flush_i      synchronous flush; drops held entries and same-cycle input
//   Valid_i      input entry valid
//   Ready_o      input can be accepted this cycle (skid register empty)
//   Instr_i      32-bit instruction word
//   ImmSrc_i     format select: I,S,B,U,J,shamt,zimm, 111 = illegal
//   Tag_i        side-band tag (typically the PC)
//   Valid_o      output entry valid
//   Ready_i      downstream accepts the output entry this cycle
//   ImmExt_o     extended immediate of the output entry
//   Tag_o        tag of the output entry
//   Illegal_o    output entry was issued with ImmSrc 111
//   Occupancy_o  number of entries held (0..2)
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int DATAWIDTH = 32,
  parameter int TAGWIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 Flush_i,
  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic [31:0]          Instr_i,
  input  logic [2:0]           ImmSrc_i,
  input  logic [TAGWIDTH-1:0]  Tag_i,
  output logic                 Valid_o,
  input  logic                 Ready_i,
  output logic [DATAWIDTH-1:0] ImmExt_o,
  output logic [TAGWIDTH-1:0]  Tag_o,
  output logic                 Illegal_o,
  output logic [1:0]           Occupancy_o
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_U     = 3'b011;
  localparam logic [2:0] SRC_J     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  // ------------------------------------------------------------------------
  // Immediate decode
  // ------------------------------------------------------------------------
  logic [31:0]          raw32;
  logic                 sext;
  logic                 ill_in;
  logic [DATAWIDTH-1:0] imm_in;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^Instr_i[6:0];

  // Every format is first assembled at 32 bits (already sign-extended within
  // 32 bits where needed), then widened to DATAWIDTH in one place.
  always_comb begin
    raw32  = '0;
    sext   = 1'b0;
    ill_in = 1'b0;
    case (ImmSrc_i)
      SRC_I: begin
        raw32 = {{20{Instr_i[31]}}, Instr_i[31:20]};
        sext  = 1'b1;
      end
      SRC_S: begin
        raw32 = {{20{Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
        sext  = 1'b1;
      end
      SRC_B: begin
        raw32 = {{19{Instr_i[31]}}, Instr_i[31], Instr_i[7],
                 Instr_i[30:25], Instr_i[11:8], 1'b0};
        sext  = 1'b1;
      end
      SRC_U: begin
        raw32 = {Instr_i[31:12], 12'b0};
        sext  = 1'b1;
      end
      SRC_J: begin
        raw32 = {{11{Instr_i[31]}}, Instr_i[31], Instr_i[19:12],
                 Instr_i[20], Instr_i[30:21], 1'b0};
        sext  = 1'b1;
      end
      SRC_SHAMT: begin
        // 64-bit shifts use a 6-bit shift amount, 32-bit shifts 5 bits.
        if (DATAWIDTH == 64) raw32 = {26'b0, Instr_i[25:20]};
        else                 raw32 = {27'b0, Instr_i[24:20]};
      end
      SRC_ZIMM: begin
        raw32 = {27'b0, Instr_i[19:15]};
      end
      default: begin
        ill_in = 1'b1;
      end
    endcase

    if (sext) imm_in = DATAWIDTH'($signed(raw32));
    else      imm_in = DATAWIDTH'(raw32);
  end

  // ------------------------------------------------------------------------
  // Output register (OUT) and skid register (SKID)
  // ------------------------------------------------------------------------
  logic                 out_valid_q,  out_valid_d;
  logic [DATAWIDTH-1:0] out_imm_q,    out_imm_d;
  logic [TAGWIDTH-1:0]  out_tag_q,    out_tag_d;
  logic                 out_ill_q,    out_ill_d;

  logic                 skid_valid_q, skid_valid_d;
  logic [DATAWIDTH-1:0] skid_imm_q,   skid_imm_d;
  logic [TAGWIDTH-1:0]  skid_tag_q,   skid_tag_d;
  logic                 skid_ill_q,   skid_ill_d;

  logic accept;
  logic advance;

  assign Ready_o = ~skid_valid_q;
  assign accept  = Valid_i & Ready_o & ~Flush_i;
  // OUT may be overwritten when empty or when its entry leaves this cycle.
  assign advance = ~out_valid_q | Ready_i;

  // The data fields are loaded only when a real entry lands. Invalid slots
  // therefore keep their last payload instead of tracking the input bus.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (Flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (advance && skid_valid_q) begin
      // Ready_o is low here, so no input can be accepted in the same cycle.
      out_valid_d  = 1'b1;
      out_imm_d    = skid_imm_q;
      out_tag_d    = skid_tag_q;
      out_ill_d    = skid_ill_q;
      skid_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = accept;
      if (accept) begin
        out_imm_d = imm_in;
        out_tag_d = Tag_i;
        out_ill_d = ill_in;
      end
    end else if (accept) begin
      // OUT is stalled: park the new entry behind it.
      skid_valid_d = 1'b1;
      skid_imm_d   = imm_in;
      skid_tag_d   = Tag_i;
      skid_ill_d   = ill_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign Valid_o   = out_valid_q;
  assign ImmExt_o  = out_imm_q;
  assign Tag_o     = out_tag_q;
  assign Illegal_o = out_ill_q;

  // SKID can only hold an entry while OUT also holds one.
  assign Occupancy_o = {out_valid_q & skid_valid_q, out_valid_q ^ skid_valid_q};

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        vin = 1'b0;
  logic        rin = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  src = '0;
  logic [31:0] tag = '0;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32, tag32;
  logic [1:0]  occ32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [1:0]  occ64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.DATAWIDTH(32), .TAGWIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .Flush_i(flush), .Valid_i(vin),
    .Ready_o(rdy32), .Instr_i(instr), .ImmSrc_i(src), .Tag_i(tag),
    .Valid_o(v32), .Ready_i(rin), .ImmExt_o(imm32), .Tag_o(tag32),
    .Illegal_o(ill32), .Occupancy_o(occ32));

  imm_extend_pipe #(.DATAWIDTH(64), .TAGWIDTH(32)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .Flush_i(flush), .Valid_i(vin),
    .Ready_o(rdy64), .Instr_i(instr), .ImmSrc_i(src), .Tag_i(tag),
    .Valid_o(v64), .Ready_i(rin), .ImmExt_o(imm64), .Tag_o(tag64),
    .Illegal_o(ill64), .Occupancy_o(occ64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate straight from the format definitions, using 64-bit arithmetic
  // on the sign-extended instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                          input int dw);
    longint s, r;
    s = longint'($signed(ins));
    case (sel)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: r = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
              | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: r = (s >>> 12) <<< 12;
      3'd4: r = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
              | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd5: r = (dw == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: r = longint'(ins[19:15]);
      default: r = 0;
    endcase
    return r;
  endfunction

  // Reference: a FIFO of at most two entries. Input is taken when fewer than
  // two are held; the head leaves whenever downstream is ready.
  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [31:0] tg;
    logic        ill;
  } ent_t;

  ent_t        mq[$];
  ent_t        me;
  int          mn;
  logic [31:0] log_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      mn = mq.size();
      if (mn > 0 && rin) void'(mq.pop_front());
      if (vin && mn < 2) begin
        me.i64 = ref_imm(instr, src, 64);
        me.i32 = ref_imm(instr, src, 32);
        me.tg  = tag;
        me.ill = (src == 3'b111);
        mq.push_back(me);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid32", v32, 0);     chk("rst_valid64", v64, 0);
      chk("rst_ready32", rdy32, 1);   chk("rst_ready64", rdy64, 1);
      chk("rst_occ32", occ32, 0);     chk("rst_occ64", occ64, 0);
      chk("rst_imm32", imm32, 0);     chk("rst_imm64", imm64, 0);
      chk("rst_tag32", tag32, 0);     chk("rst_ill64", ill64, 0);
    end else begin
      chk("valid32", v32, mq.size() > 0);
      chk("valid64", v64, mq.size() > 0);
      chk("occ32", occ32, mq.size());
      chk("occ64", occ64, mq.size());
      chk("ready32", rdy32, mq.size() < 2);
      chk("ready64", rdy64, mq.size() < 2);
      if (mq.size() > 0) begin
        chk("imm32", imm32, mq[0].i32);
        chk("imm64", imm64, mq[0].i64);
        chk("tag32", tag32, mq[0].tg);
        chk("tag64", tag64, mq[0].tg);
        chk("ill32", ill32, mq[0].ill);
        chk("ill64", ill64, mq[0].ill);
      end
      if (v32 && rin) log_q.push_back(tag32);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t_ins [5];
  logic [2:0]  t_src [5];
  logic [63:0] t_exp [5];
  logic        t_ill [5];

  initial begin
    int t, cyc, cnt;
    logic saw_full, saw_stall;

    // Pin the reference model to hand-decoded values.
    chk("pin_I",   ref_imm(32'hFFF00093, 3'd0, 32) & 64'hFFFFFFFF, 64'hFFFFFFFF);
    chk("pin_S",   ref_imm(32'hFE112E23, 3'd1, 32) & 64'hFFFFFFFF, 64'hFFFFFFFC);
    chk("pin_B",   ref_imm(32'hFE000CE3, 3'd2, 32) & 64'hFFFFFFFF, 64'hFFFFFFF8);
    chk("pin_U",   ref_imm(32'h123450B7, 3'd3, 32) & 64'hFFFFFFFF, 64'h12345000);
    chk("pin_J",   ref_imm(32'h0010006F, 3'd4, 32) & 64'hFFFFFFFF, 64'h00000800);
    chk("pin_U64", ref_imm(32'h800000B7, 3'd3, 64), 64'hFFFFFFFF80000000);
    chk("pin_sh64", ref_imm(32'h03F00013, 3'd5, 64), 64'h3F);
    chk("pin_sh32", ref_imm(32'h03F00013, 3'd5, 32), 64'h1F);
    chk("pin_zimm", ref_imm(32'h000F8073, 3'd6, 64), 64'h1F);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rin = 1'b1;

    // Back-to-back 32-bit formats, one result per cycle.
    t_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F};
    t_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    t_exp = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000, 64'h00000800};
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k < 5) begin
        vin = 1'b1; instr = t_ins[k]; src = t_src[k]; tag = 32'h100 + k;
      end else begin
        vin = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        chk("b2b_valid", v32, 1);
        chk("b2b_imm32", imm32, t_exp[k-1]);
        chk("b2b_tag", tag32, 32'h100 + k - 1);
      end
    end

    // 64-bit formats including the illegal code.
    t_ins = '{32'h800000B7, 32'h03F00013, 32'h000F8073, 32'hFFFFFFFF, 32'h00000000};
    t_src = '{3'd3, 3'd5, 3'd6, 3'd7, 3'd0};
    t_exp = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1F, 64'h0, 64'h0};
    t_ill = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k <= 4; k++) begin
      step();
      if (k < 4) begin
        vin = 1'b1; instr = t_ins[k]; src = t_src[k]; tag = 32'h200 + k;
      end else begin
        vin = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        chk("d64_imm", imm64, t_exp[k-1]);
        chk("d64_ill", ill64, t_ill[k-1]);
        chk("d64_tag", tag64, 32'h200 + k - 1);
      end
    end

    // Backpressure: tags 1..6 with a three-cycle downstream stall.
    step();
    log_q.delete();
    t = 1; cyc = 0; saw_full = 1'b0; saw_stall = 1'b0;
    while (t <= 6 && cyc < 50) begin
      step();
      vin = 1'b1; tag = t; instr = $urandom; src = 3'($urandom_range(0, 6));
      rin = !(cyc >= 3 && cyc < 6);
      if (occ32 == 2'd2) saw_full = 1'b1;
      if (!rdy32) saw_stall = 1'b1;
      if (rdy32) t++;
      cyc++;
    end
    chk("bp_all_sent", t, 7);
    step();
    vin = 1'b0; rin = 1'b1;
    repeat (4) step();
    chk("bp_saw_full", saw_full, 1);
    chk("bp_saw_stall", saw_stall, 1);
    chk("bp_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) chk("bp_order", log_q[i], i + 1);

    // Flush while full with a valid input presented.
    log_q.delete();
    rin = 1'b0;
    step(); vin = 1'b1; tag = 32'hA1; instr = $urandom; src = 3'd0;
    step(); tag = 32'hA2;
    step();
    chk("fl_pre_occ", occ32, 2);
    flush = 1'b1; vin = 1'b1; tag = 32'hDEAD;
    step();
    flush = 1'b0; vin = 1'b0;
    @(negedge clk);
    chk("fl_valid", v32, 0);
    chk("fl_occ", occ32, 0);
    chk("fl_ready", rdy32, 1);
    rin = 1'b1;
    repeat (3) step();
    cnt = 0;
    foreach (log_q[i]) if (log_q[i] == 32'hDEAD) cnt++;
    chk("fl_dropped", cnt, 0);
    chk("fl_log_empty", log_q.size(), 0);

    // Asynchronous reset between clock edges, mid-stream.
    rin = 1'b0;
    vin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); tag = 32'h300 + k; instr = $urandom; src = 3'd1;
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", v32, 0);
    chk("ar_occ", occ32, 0);
    chk("ar_ready", rdy32, 1);
    chk("ar_imm", imm64, 0);
    chk("ar_tag", tag32, 0);
    vin = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    rin = 1'b1;
    step(); vin = 1'b1; tag = 32'h5A5A; instr = 32'h00100013; src = 3'd0;
    step(); vin = 1'b0;
    @(negedge clk);
    chk("ar_first_valid", v32, 1);
    chk("ar_first_tag", tag32, 32'h5A5A);
    chk("ar_first_imm", imm32, 32'h1);

    // Random traffic against the reference model.
    repeat (10000) begin
      step();
      vin   = ($urandom % 4) != 0;
      rin   = ($urandom % 10) < 7;
      flush = ($urandom % 32) == 0;
      instr = $urandom;
      src   = 3'($urandom_range(0, 7));
      tag   = $urandom;
    end
    step();
    flush = 1'b0; vin = 1'b0; rin = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 1500000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator sitting between instruction fetch/decode and the execute stage. Accepts a 32-bit instruction word plus an immediate-format select and a tag (typically the PC), and produces the sign- or zero-extended immediate at DATAWIDTH (32 or 64). Output is registered behind a two-entry skid buffer with valid/ready handshakes on both sides, a synchronous flush and an illegal-format flag. It sustains one instruction per cycle with 1-cycle latency.

## Interface
- DATAWIDTH, 32: immediate output width; legal values 32 or 64.
- TAGWIDTH, 32: width of the side-band tag carried alongside each immediate.

- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- Flush_i  in  1  synchronous; discard all buffered entries and any same-cycle input
- Valid_i  in  1  input entry valid
- Ready_o  out  1  block can accept an input this cycle
- Instr_i  in  32  instruction word
- ImmSrc_i  in  3  format select (encoding under Operation)
- Tag_i  in  TAGWIDTH  side-band tag
- Valid_o  out  1  output entry valid
- Ready_i  in  1  downstream accepts output this cycle
- ImmExt_o  out  DATAWIDTH  extended immediate
- Tag_o  out  TAGWIDTH  tag of the output entry
- Illegal_o  out  1  output entry had ImmSrc 111
- Occupancy_o  out  2  entries held: Valid_o + skid-valid (0..2)

## Operation
- Formats; s = sign-extend Instr_i[31] to DATAWIDTH, z = zero-extend:
  - 000 I: s{Instr[31:20]}
  - 001 S: s{Instr[31:25], Instr[11:7]}
  - 010 B: s{Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}
  - 011 U: s{Instr[31:12], 12'b0}
  - 100 J: s{Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}
  - 101 shamt: z{Instr[24:20]} at DATAWIDTH=32; z{Instr[25:20]} at 64
  - 110 CSR zimm: z{Instr[19:15]}
  - 111: ImmExt = 0, Illegal = 1
- Immediate is computed combinationally from Instr_i/ImmSrc_i and captured into storage on accept. Illegal is 0 for all other codes.
- Storage: output register (OUT) and one skid register (SKID), each holding {valid, imm, tag, illegal}.
- accept = Valid_i && Ready_o && !Flush_i. advance = !Valid_o || Ready_i.
- Ready_o = !SKID.valid. Purely registered; no combinational path from Ready_i.
- Per-cycle update, first matching rule wins:
  - Flush_i: OUT.valid <= 0, SKID.valid <= 0.
  - advance && SKID.valid: OUT <= SKID, SKID.valid <= 0. accept is impossible here because Ready_o = 0.
  - advance: OUT <= input entry, OUT.valid <= accept.
  - !advance && accept: SKID <= input entry, SKID.valid <= 1.
- Ordering is strictly FIFO. The entry in OUT and its payload are held stable while Valid_o && !Ready_i.
- Data fields of invalid entries are don't-care internally but must keep their last values, with no X on outputs.

## Timing
- Reset (async assert, sync-free deassert): Valid_o = 0, ImmExt_o = 0, Tag_o = 0, Illegal_o = 0, Occupancy_o = 0, Ready_o = 1, SKID cleared.
- Latency: input accepted at edge N appears on outputs after edge N; Valid_o is high in cycle N+1.
- Throughput: 1 entry/cycle while Ready_i is held high.
- Backpressure: when Ready_i drops with OUT valid, one more input is absorbed into SKID. Ready_o falls the following cycle and stays low until SKID drains.
- Full (Occupancy 2): Ready_o = 0. When Ready_i rises, OUT takes SKID at that edge and Ready_o returns to 1 in the next cycle.
- Flush with Valid_i high: the input is dropped. Occupancy_o = 0 and Ready_o = 1 the cycle after.
- Reset mid-stream: all entries lost immediately on assertion; no output handshake completes.

## Test plan
- Reset, then DATAWIDTH=32 back-to-back with Ready_i=1: I 0xFFF00093 -> 0xFFFFFFFF; S 0xFE112E23 -> 0xFFFFFFFC; B 0xFE000CE3 -> 0xFFFFFFF8; U 0x123450B7 -> 0x12345000; J 0x0010006F -> 0x00000800. Each result appears one cycle later with the matching tag, at a rate of 1 per cycle.
- DATAWIDTH=64: U 0x800000B7 -> 0xFFFFFFFF80000000; shamt with Instr[25:20]=0x3F -> 0x3F; zimm with Instr[19:15]=0x1F -> 0x1F; ImmSrc 111 -> imm 0, Illegal_o = 1.
- Backpressure: stream tags 1..6, hold Ready_i=0 for 3 cycles mid-stream. Occupancy reaches 2 and Ready_o goes low; all tags arrive in order with none lost or duplicated.
- Flush with Occupancy 2 and Valid_i high: next cycle Valid_o = 0, Occupancy_o = 0, Ready_o = 1. The flushed-cycle input never appears.
- Assert rst_n_i asynchronously mid-stream, between clock edges: outputs go to reset values immediately. After release, the first new input emerges one cycle after it is accepted.
- Random valid/ready/flush for 10k cycles, checked against a reference model: outputs stay stable under stall, order is preserved, and Ready_o == (Occupancy_o < 2) whenever OUT is valid.
